// File: rtl/tiny_slot_sequencer.sv
// tiny_slot_sequencer: Wishbone-controlled driver for the 8-bit tiny user
// design slot. Generates the slot clock on tiny_io_in[0] with a programmable
// half-period, holds static stimulus on tiny_io_in[7:1], runs a counted or
// free-running burst of slot clocks and captures tiny_io_out on each one.
module tiny_slot_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [7:0]  tiny_io_in,
    input  logic [7:0]  tiny_io_out,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t state, state_next;

    // bus decode
    logic             bus_req;
    logic             bus_held;
    logic             access;
    logic             wr_en;
    logic [2:0]       reg_sel;
    logic [31:0]      rdata;

    // programmer-visible registers
    logic [15:0]      div;
    logic [7:1]       stim;
    logic             free_run;
    logic             irq_en;
    logic             done;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] executed;
    logic [7:0]       capture;

    // one-cycle command pulses from CTRL writes
    logic             start_pulse;
    logic             stop_pulse;

    // sequencing
    logic [15:0]      phase_cnt;
    logic [15:0]      half_period;
    logic             phase_last;
    logic             start_accept;
    logic             last_high;
    logic             run_allowed;
    logic             final_cycle;
    logic             done_set;
    logic             done_clr;
    logic             slot_clk;
    logic             busy;

    // write data merged with byte enables
    logic [31:0]      remaining_ext;
    logic [31:0]      count_merged;
    logic [31:0]      div_merged;
    logic             unused_bits;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return result;
    endfunction

    // An access is taken once per request: the cycle after an ack and any
    // further cycles the master keeps the same request up are not re-acked.
    assign bus_req = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign access  = bus_req && !wbs_ack_o && !bus_held;
    assign wr_en   = access && wbs_we_i;
    assign reg_sel = wbs_adr_i[4:2];

    assign count_merged = byte_merge(remaining_ext, wbs_dat_i, wbs_sel_i);
    assign div_merged   = byte_merge({16'h0000, div}, wbs_dat_i, wbs_sel_i);

    assign half_period  = (div < 16'd2) ? 16'd2 : div;
    assign phase_last   = (phase_cnt == 16'd1);
    assign start_accept = (state == IDLE) && start_pulse && !stop_pulse;
    assign last_high    = (state == HIGH) && phase_last && !stop_pulse;
    assign run_allowed  = free_run || (remaining != '0);
    assign final_cycle  = !free_run && (remaining_ext <= 32'd1);
    assign done_set     = (start_accept && !run_allowed) || (last_high && final_cycle);
    assign done_clr     = start_accept ||
                          (wr_en && (reg_sel == 3'd0) && wbs_sel_i[1] && wbs_dat_i[9]);

    assign tiny_io_in   = {stim, slot_clk};
    assign unused_bits  = ^{wbs_adr_i[1:0], count_merged[31:CNT_W], div_merged[31:16]};

    // Zero-extend the remaining count so it can be merged and compared as a word.
    always_comb begin
        remaining_ext = '0;
        remaining_ext[CNT_W-1:0] = remaining;
    end

    // Register read multiplexer; unmapped offsets read as zero.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            3'd0: begin
                rdata[2] = free_run;
                rdata[3] = irq_en;
                rdata[8] = busy;
                rdata[9] = done;
            end
            3'd1: rdata[15:0] = div;
            3'd2: rdata[7:1]  = stim;
            3'd3: rdata = remaining_ext;
            3'd4: begin
                rdata[7:0]        = capture;
                rdata[16 +: CNT_W] = executed;
            end
            default: rdata = '0;
        endcase
    end

    // Ack generation and tracking of a request that stays up after its ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            bus_held  <= 1'b0;
        end else begin
            wbs_ack_o <= access;
            bus_held  <= bus_req && (bus_held || wbs_ack_o);
        end
    end

    // Read data is presented only in the ack cycle of a read.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_dat_o <= '0;
        end else begin
            wbs_dat_o <= (access && !wbs_we_i) ? rdata : 32'h0;
        end
    end

    // Static configuration registers and the START/STOP command pulses.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            div         <= '0;
            stim        <= '0;
            free_run    <= 1'b0;
            irq_en      <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
        end else begin
            start_pulse <= wr_en && (reg_sel == 3'd0) && wbs_sel_i[0] && wbs_dat_i[0];
            stop_pulse  <= wr_en && (reg_sel == 3'd0) && wbs_sel_i[0] && wbs_dat_i[1];
            if (wr_en && (reg_sel == 3'd0) && wbs_sel_i[0]) begin
                free_run <= wbs_dat_i[2];
                irq_en   <= wbs_dat_i[3];
            end
            if (wr_en && (reg_sel == 3'd1)) begin
                div <= div_merged[15:0];
            end
            if (wr_en && (reg_sel == 3'd2) && wbs_sel_i[0]) begin
                stim <= wbs_dat_i[7:1];
            end
        end
    end

    // Remaining count: loaded only while idle, counts down on each completed slot clock.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            remaining <= '0;
        end else if (wr_en && (reg_sel == 3'd3) && !busy) begin
            remaining <= count_merged[CNT_W-1:0];
        end else if (last_high && !free_run && (remaining != '0)) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    // Executed count restarts on an accepted START and saturates at all-ones.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            executed <= '0;
        end else if (start_accept) begin
            executed <= '0;
        end else if (last_high && (executed != '1)) begin
            executed <= executed + CNT_W'(1);
        end
    end

    // Sample the slot outputs at the end of each high phase, well after its rising edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            capture <= '0;
        end else if (last_high) begin
            capture <= tiny_io_out;
        end
    end

    // DONE flag: a set in the same cycle as a clear takes priority.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            done <= 1'b0;
        end else if (done_set) begin
            done <= 1'b1;
        end else if (done_clr) begin
            done <= 1'b0;
        end
    end

    // Registered level interrupt.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq <= 1'b0;
        end else begin
            irq <= done && irq_en;
        end
    end

    // Phase timer: reloads on every state change so a new DIV lands at the next phase.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            phase_cnt <= '0;
        end else if ((state == IDLE) || (state_next != state)) begin
            phase_cnt <= half_period;
        end else begin
            phase_cnt <= phase_cnt - 16'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; STOP overrides everything else.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_accept && run_allowed) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (phase_last) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    state_next = final_cycle ? IDLE : LOW;
                end
            end
            default: state_next = IDLE;
        endcase
        if (stop_pulse) begin
            state_next = IDLE;
        end
    end

    // FSM outputs: slot clock is high only in HIGH, so reset drops it at once.
    always_comb begin
        slot_clk = (state == HIGH);
        busy     = (state != IDLE);
    end

endmodule

// File: doc/tiny_slot_sequencer.md
# tiny_slot_sequencer

Wishbone-controlled sequencer that drives the 8-bit tiny user design slot inside the user project wrapper. It generates the slot's clock on `tiny_io_in[0]` with a programmable divider and drives static stimulus on `tiny_io_in[7:1]`. It runs a programmed number of slot clock cycles (or free-runs) and captures `tiny_io_out[7:0]` after each slot clock. A done flag and an interrupt let firmware run and observe the design without bit-banging GPIOs.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: Wishbone base address. The block decodes `wbs_adr_i[31:5] == BASE_ADDR[31:5]`.
- `CNT_W`, default 16: width of the cycle counters.

Ports:
- `wb_clk_i`  in  1  system clock; the single clock of the block.
- `wb_rst_ni`  in  1  reset, asynchronous, active-low.
- `wbs_cyc_i`  in  1  Wishbone cycle.
- `wbs_stb_i`  in  1  Wishbone strobe.
- `wbs_we_i`  in  1  write enable.
- `wbs_sel_i`  in  4  byte enables; honoured on every write.
- `wbs_adr_i`  in  32  byte address; `[4:2]` selects the register.
- `wbs_dat_i`  in  32  write data.
- `wbs_dat_o`  out  32  read data.
- `wbs_ack_o`  out  1  Wishbone acknowledge.
- `tiny_io_in`  out  8  to the slot: `[0]` is the slot clock, `[7:1]` is stimulus.
- `tiny_io_out`  in  8  from the slot.
- `irq`  out  1  level interrupt.

## Operation
Register map (word offset):
- **0 CTRL**: bit0 START (write-1 pulse), bit1 STOP (write-1 pulse), bit2 FREE_RUN, bit3 IRQ_EN, bit8 BUSY (read-only), bit9 DONE (write-1-to-clear).
- **1 DIV**: `[15:0]` half-period in `wb_clk_i` cycles. Effective half-period is max(DIV,2).
- **2 STIM**: `[7:1]` drive `tiny_io_in[7:1]`. Bit0 reads 0 and ignores writes.
- **3 COUNT**: write `[CNT_W-1:0]` to set cycles to run. Read returns the remaining count.
- **4 CAPTURE**: `[7:0]` last captured `tiny_io_out`; `[16+CNT_W-1:16]` cycles executed since START.
- **Offsets 5-7**: read 0; writes are ignored. Both are still acked.

FSM states:
- **IDLE**
  - Slot clock = 0.
  - START with STOP=0 clears DONE and the executed count.
  - If COUNT>0 or FREE_RUN=1, go to LOW.
  - Otherwise set DONE and stay in IDLE.
- **LOW**
  - Slot clock = 0 for the half-period, then go to HIGH.
- **HIGH**
  - Slot clock = 1 for the half-period.
  - On the last HIGH cycle: load CAPTURE from `tiny_io_out`, increment executed, and decrement remaining if FREE_RUN=0.
  - If the decremented remaining = 0, set DONE and go to IDLE; else go to LOW.

Rules:
- BUSY = (state != IDLE).
- STOP in any state goes to IDLE on the next cycle with slot clock 0. Remaining and CAPTURE are kept; DONE is not set.
- START and STOP written together: STOP wins.
- START while BUSY is ignored.
- DIV, STIM and FREE_RUN writes take effect immediately, including mid-run. A new DIV applies at the next phase reload.
- COUNT writes while BUSY are ignored.
- Executed counter saturates at all-ones. Remaining never wraps below 0.
- `irq` = DONE & IRQ_EN, registered.
- A DONE clear and a DONE set in the same cycle: set wins.

Reset values:
- `tiny_io_in` = 8'h00, `wbs_ack_o` = 0, `wbs_dat_o` = 0, `irq` = 0.
- All registers 0; DIV = 0, so the effective half-period is 2.
- State is IDLE.

## Timing
- A Wishbone access is acked one cycle after `cyc&stb` with an address match. Ack is a single-cycle pulse.
- A request still held in the cycle after its ack is not acked again. Each access is acked exactly once.
- An address mismatch produces no ack.
- Read data is valid in the ack cycle. Write side effects are visible from the ack cycle.
- START is sampled on the write's ack cycle. LOW is entered on the following edge.
- Slot clock period = 2×max(DIV,2) `wb_clk_i` cycles.
- Capture occurs at least 2 `wb_clk_i` cycles after the slot rising edge.
- DONE is set on the edge that leaves the final HIGH. `irq` follows one cycle later.
- Reset assertion forces all outputs to reset values asynchronously, including mid-run. The slot clock drops to 0 immediately.

## Test plan
- **Reset and map:** assert `wb_rst_ni`=0 mid-run -> `tiny_io_in`=0, `irq`=0, BUSY=0. Read offsets 0..7 after release -> all 0.
- **Counted run:**
  - Stimulus: DIV=3, COUNT=4, STIM=8'hA4, START; slot model echoes a counter.
  - Required: 4 slot-clock pulses, each 3 high / 3 low cycles, with `tiny_io_in[7:1]`=7'h52 throughout.
  - At finish: CAPTURE=8'h04, executed=4, remaining=0, DONE=1.
- **IRQ:** IRQ_EN=1, COUNT=1, START -> `irq` rises one cycle after DONE. Writing CTRL with bit9=1 -> DONE=0 and `irq`=0 next cycle.
- **Stop and priority:**
  - FREE_RUN=1, START, then STOP after 10 slot clocks -> IDLE with slot clock 0, DONE=0, executed=10.
  - START and STOP in one write -> no slot clock edge.
- **Edge cases:**
  - COUNT=0, START -> DONE=1, no slot clock edge.
  - START while BUSY -> no restart.
  - DIV=0 -> period 4 cycles.
  - `wbs_sel_i`=4'b0001 write to COUNT=32'hFFFF_FFFF -> COUNT=16'h00FF.
- **Bus:** write with the address outside BASE_ADDR -> no ack and no state change. A `stb` held for 3 cycles -> exactly one ack.
